// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice slot allocator (retrigger, else free, else steal oldest).
// Define VOICE_ALLOCATOR_STEAL_EN to steal the oldest voice when all voices are active.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7
) (
    input  logic                             clock_50_000_000,
    input  logic                             reset_l,
    input  logic                             note_status,
    input  logic [NOTE_WIDTH-1:0]            note_number,
    input  logic [VEL_WIDTH-1:0]             note_velocity,
    input  logic                             note_ready,
    output logic                             busy,
    output logic [NUM_VOICES-1:0]            voice_active,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]            voice_start,
    output logic [7:0]                       drop_count
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                state_q;
    logic                  busy_q;
    logic [IW-1:0]         idx_q;
    logic                  lat_on_q;
    logic [NOTE_WIDTH-1:0] lat_note_q;
    logic [VEL_WIDTH-1:0]  lat_vel_q;
    logic                  match_v_q, free_v_q;
    logic [IW-1:0]         match_i_q, free_i_q;
    logic [NUM_VOICES-1:0] active_q, start_q;
    logic [NOTE_WIDTH-1:0] note_q [NUM_VOICES];
    logic [VEL_WIDTH-1:0]  vel_q [NUM_VOICES];
    logic [IW-1:0]         rank_q [NUM_VOICES];
    logic [7:0]            drop_q, drop_d;
    logic [1:0]            drop_inc;
    logic                  tgt_v;
    logic [IW-1:0]         tgt_i;

`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic                  old_v_q;
    logic [IW-1:0]         old_i_q, old_r_q;
    assign tgt_v = match_v_q | free_v_q | old_v_q;
    assign tgt_i = match_v_q ? match_i_q : free_v_q ? free_i_q : old_i_q;
`else
    assign tgt_v = match_v_q | free_v_q;
    assign tgt_i = match_v_q ? match_i_q : free_i_q;
`endif

    // Events arriving while busy and ON events with no target can coincide in COMMIT.
    assign drop_inc = 2'(note_ready && busy_q) + 2'(state_q == COMMIT && lat_on_q && !tgt_v);
    assign drop_d   = ({1'b0, drop_q} + 9'(drop_inc) > 9'd255) ? 8'd255 : drop_q + 8'(drop_inc);

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            lat_on_q   <= 1'b0;
            lat_note_q <= '0;
            lat_vel_q  <= '0;
            match_v_q  <= 1'b0;
            match_i_q  <= '0;
            free_v_q   <= 1'b0;
            free_i_q   <= '0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            old_v_q    <= 1'b0;
            old_i_q    <= '0;
            old_r_q    <= '0;
`endif
            active_q   <= '0;
            start_q    <= '0;
            drop_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                rank_q[i] <= IW'(i);
            end
        end else begin
            start_q <= '0;
            drop_q  <= drop_d;
            case (state_q)
                IDLE: if (note_ready) begin
                    state_q    <= SCAN;
                    busy_q     <= 1'b1;
                    idx_q      <= '0;
                    lat_on_q   <= note_status && (note_velocity != '0);
                    lat_note_q <= note_number;
                    lat_vel_q  <= note_velocity;
                    match_v_q  <= 1'b0;
                    free_v_q   <= 1'b0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
                    old_v_q    <= 1'b0;
`endif
                end
                SCAN: begin
                    if (!match_v_q && active_q[idx_q] && note_q[idx_q] == lat_note_q) begin
                        match_v_q <= 1'b1;
                        match_i_q <= idx_q;
                    end
                    if (!free_v_q && !active_q[idx_q]) begin
                        free_v_q <= 1'b1;
                        free_i_q <= idx_q;
                    end
`ifdef VOICE_ALLOCATOR_STEAL_EN
                    if (active_q[idx_q] && (!old_v_q || rank_q[idx_q] > old_r_q)) begin
                        old_v_q <= 1'b1;
                        old_i_q <= idx_q;
                        old_r_q <= rank_q[idx_q];
                    end
`endif
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(NUM_VOICES - 1))
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (lat_on_q && tgt_v) begin
                        note_q[tgt_i]   <= lat_note_q;
                        vel_q[tgt_i]    <= lat_vel_q;
                        active_q[tgt_i] <= 1'b1;
                        start_q[tgt_i]  <= 1'b1;
                        for (int i = 0; i < NUM_VOICES; i++)
                            if (rank_q[i] < rank_q[tgt_i])
                                rank_q[i] <= rank_q[i] + IW'(1);
                        rank_q[tgt_i] <= '0;
                    end else if (!lat_on_q && match_v_q) begin
                        active_q[match_i_q] <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign voice_note[v*NOTE_WIDTH +: NOTE_WIDTH]  = note_q[v];
        assign voice_velocity[v*VEL_WIDTH +: VEL_WIDTH] = vel_q[v];
    end

    assign busy         = busy_q;
    assign voice_active = active_q;
    assign voice_start  = start_q;
    assign drop_count   = drop_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed test-plan checks plus random events against a queue-based reference model.
module tb_voice_allocator;
    localparam int N  = 4;
    localparam int NW = 7;
    localparam int VW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            note_status;
    logic [NW-1:0]   note_number;
    logic [VW-1:0]   note_velocity;
    logic            note_ready;
    logic            busy;
    logic [N-1:0]    voice_active, voice_start;
    logic [N*NW-1:0] voice_note;
    logic [N*VW-1:0] voice_velocity;
    logic [7:0]      drop_count;

    int checks = 0;
    int errors = 0;

    voice_allocator #(.NUM_VOICES(N), .NOTE_WIDTH(NW), .VEL_WIDTH(VW)) dut (
        .clock_50_000_000(clk),
        .reset_l(rst_n),
        .note_status(note_status),
        .note_number(note_number),
        .note_velocity(note_velocity),
        .note_ready(note_ready),
        .busy(busy),
        .voice_active(voice_active),
        .voice_note(voice_note),
        .voice_velocity(voice_velocity),
        .voice_start(voice_start),
        .drop_count(drop_count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: voices as plain arrays, age as a recency-ordered queue (front = newest).
    int       m_cnt, m_nn, m_vv, m_drop;
    bit       m_on;
    bit [N-1:0] m_act, m_start;
    int       m_note [N];
    int       m_vel [N];
    int       m_order [$];

    always @(posedge clk or negedge rst_n) begin : model
        int t, mt;
        if (!rst_n) begin
            m_cnt = 0; m_drop = 0; m_act = '0; m_start = '0;
            m_order = {};
            for (int i = 0; i < N; i++) begin
                m_note[i] = 0; m_vel[i] = 0; m_order.push_back(i);
            end
        end else begin
            m_start = '0;
            if (m_cnt > 0) begin
                if (note_ready && m_drop < 255) m_drop++;
                m_cnt--;
                if (m_cnt == 0) begin
                    mt = -1;
                    for (int i = 0; i < N; i++)
                        if (mt < 0 && m_act[i] && m_note[i] == m_nn) mt = i;
                    if (m_on) begin
                        t = mt;
                        for (int i = 0; i < N; i++)
                            if (t < 0 && !m_act[i]) t = i;
`ifdef VOICE_ALLOCATOR_STEAL_EN
                        if (t < 0) t = m_order[N-1];
`endif
                        if (t < 0) begin
                            if (m_drop < 255) m_drop++;
                        end else begin
                            m_note[t] = m_nn; m_vel[t] = m_vv; m_act[t] = 1'b1; m_start[t] = 1'b1;
                            for (int k = 0; k < m_order.size(); k++)
                                if (m_order[k] == t) begin m_order.delete(k); break; end
                            m_order.push_front(t);
                        end
                    end else if (mt >= 0) begin
                        m_act[mt] = 1'b0;
                    end
                end
            end else if (note_ready) begin
                m_on = note_status && note_velocity != 0;
                m_nn = int'(note_number);
                m_vv = int'(note_velocity);
                m_cnt = N + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N*NW-1:0] en;
        logic [N*VW-1:0] ev;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                en[i*NW +: NW] = NW'(m_note[i]);
                ev[i*VW +: VW] = VW'(m_vel[i]);
            end
            chk("busy", 64'(busy), 64'(m_cnt > 0));
            chk("voice_active", 64'(voice_active), 64'(m_act));
            chk("voice_start", 64'(voice_start), 64'(m_start));
            chk("voice_note", 64'(voice_note), 64'(en));
            chk("voice_velocity", 64'(voice_velocity), 64'(ev));
            chk("drop_count", 64'(drop_count), 64'(m_drop));
        end
    end

    task automatic pulse(input logic st, input int n, input int v);
        note_status = st; note_number = NW'(n); note_velocity = VW'(v); note_ready = 1'b1;
        @(negedge clk);
        note_ready = 1'b0;
    endtask

    task automatic send(input logic st, input int n, input int v);
        pulse(st, n, v);
        repeat (N + 1) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; note_ready = 1'b0; note_status = 1'b0; note_number = '0; note_velocity = '0;
        repeat (2) @(negedge clk);
        chk("reset_active", 64'(voice_active), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        pulse(1'b1, 60, 100);
        chk("busy_cycle1", 64'(busy), 64'd1);
        repeat (N + 1) @(negedge clk);
        chk("first_active", 64'(voice_active), 64'b0001);
        chk("first_note", 64'(voice_note[NW-1:0]), 64'd60);
        chk("first_vel", 64'(voice_velocity[VW-1:0]), 64'd100);
        chk("first_start", 64'(voice_start), 64'b0001);
        chk("first_busy_low", 64'(busy), 64'd0);
        @(negedge clk);
        chk("first_start_end", 64'(voice_start), 64'd0);

        do_reset();
        send(1'b1, 60, 90); send(1'b1, 62, 90); send(1'b1, 64, 90); send(1'b1, 65, 90);
        send(1'b0, 62, 0);
        chk("release_active", 64'(voice_active), 64'b1101);
        send(1'b1, 67, 80);
        chk("refill_note1", 64'(voice_note[2*NW-1:NW]), 64'd67);
        chk("refill_active", 64'(voice_active), 64'b1111);

        do_reset();
        send(1'b1, 60, 100); @(negedge clk);
        send(1'b1, 60, 30);
        chk("retrig_active", 64'(voice_active), 64'b0001);
        chk("retrig_vel", 64'(voice_velocity[VW-1:0]), 64'd30);
        chk("retrig_start", 64'(voice_start), 64'b0001);

        do_reset();
        send(1'b1, 60, 90); send(1'b1, 62, 90); send(1'b1, 64, 90); send(1'b1, 65, 90);
        send(1'b1, 67, 70);
`ifdef VOICE_ALLOCATOR_STEAL_EN
        chk("steal_note0", 64'(voice_note[NW-1:0]), 64'd67);
        chk("steal_start", 64'(voice_start), 64'b0001);
        chk("steal_drop", 64'(drop_count), 64'd0);
`else
        chk("full_note0", 64'(voice_note[NW-1:0]), 64'd60);
        chk("full_start", 64'(voice_start), 64'd0);
        chk("full_drop", 64'(drop_count), 64'd1);
`endif

        do_reset();
        send(1'b1, 60, 100);
        send(1'b1, 60, 0);
        chk("vel0_off", 64'(voice_active), 64'd0);
        send(1'b0, 70, 0);
        chk("off_nomatch_active", 64'(voice_active), 64'd0);
        chk("off_nomatch_drop", 64'(drop_count), 64'd0);

        do_reset();
        pulse(1'b1, 60, 100);
        pulse(1'b1, 70, 100);
        repeat (N) @(negedge clk);
        chk("busy_drop", 64'(drop_count), 64'd1);
        chk("busy_drop_active", 64'(voice_active), 64'b0001);
        do_reset();
        pulse(1'b1, 62, 50);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_active", 64'(voice_active), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_note", 64'(voice_note), 64'd0);
        chk("midreset_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 3) @(negedge clk);
        chk("midreset_nowrite", 64'(voice_active), 64'd0);

        do_reset();
        note_status = 1'b1; note_number = 7'd60; note_velocity = 7'd50; note_ready = 1'b1;
        repeat (400) @(negedge clk);
        note_ready = 1'b0;
        repeat (N + 2) @(negedge clk);
        chk("drop_saturate", 64'(drop_count), 64'd255);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                note_ready = 1'b0;
                do_reset();
            end
            note_ready    = ($urandom_range(0, 3) == 0);
            note_status   = ($urandom_range(0, 3) != 0);
            note_number   = NW'(60 + $urandom_range(0, 7));
            note_velocity = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom_range(1, 127));
            @(negedge clk);
        end
        note_ready = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the MIDI front end and the synthesis pipelines. It takes single-cycle note-change strobes and assigns each note to one of `NUM_VOICES` voice slots. Policy, in priority order: retrigger the voice already holding the same note, else use a free voice, else steal the oldest voice. Per-voice note, velocity, active flag and start pulse drive one oscillator/pipeline instance per voice; the start pulse feeds that oscillator's phase-clear input.

## Interface
- `NUM_VOICES`, default 4: number of voice slots, 2..16.
- `NOTE_WIDTH`, default 7: MIDI note-number width.
- `VEL_WIDTH`, default 7: MIDI velocity width.

Ports:
- `clock_50_000_000` in 1: sole clock; all state on its rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `note_status` in 1: 1 = ON, 0 = OFF.
- `note_number` in `NOTE_WIDTH`: note of the event.
- `note_velocity` in `VEL_WIDTH`: velocity of the event.
- `note_ready` in 1: single-cycle event strobe.
- `busy` out 1: allocator is processing an event.
- `voice_active` out `NUM_VOICES`: bit i high means voice i is sounding.
- `voice_note` out `NUM_VOICES*NOTE_WIDTH`: voice i at bits [i*NOTE_WIDTH +: NOTE_WIDTH].
- `voice_velocity` out `NUM_VOICES*VEL_WIDTH`: packed the same way.
- `voice_start` out `NUM_VOICES`: one-cycle pulse when voice i is (re)triggered.
- `drop_count` out 8: saturating count of discarded events.

## Operation
- FSM states:
  - IDLE: on `note_ready`, latch status, note and velocity, clear the scan results, go to SCAN with idx=0.
  - SCAN: examine voice idx once per cycle, for `NUM_VOICES` cycles, then go to COMMIT.
  - COMMIT: apply the decision for one cycle, then return to IDLE.
- An ON event with velocity 0 is treated as OFF.
- SCAN records, lowest index first:
  - match: first voice that is active with `voice_note` equal to the latched note.
  - free: first inactive voice.
  - oldest: active voice with the maximum age rank.
- COMMIT, ON event:
  - Target is match, else free, else oldest (oldest only if stealing is enabled; see Configuration).
  - Write note and velocity into the target, set it active, pulse `voice_start[target]`.
  - Age update: ranks strictly below the target's old rank increment; the target's rank becomes 0.
  - If there is no target, drop the event and increment `drop_count`.
- COMMIT, OFF event:
  - If match exists, clear `voice_active[match]`; note, velocity and rank are kept.
  - If no match exists, do nothing. This is not a drop.
- `note_ready` asserted while `busy`=1 is discarded and increments `drop_count`.
- `drop_count` saturates at 255.
- Age ranks always form a permutation of 0..`NUM_VOICES`-1.
- Only one voice can ever hold a given note, because of the retrigger rule.

## Timing
- Cycle 0: `note_ready` is sampled high in IDLE.
- Cycles 1..`NUM_VOICES`: SCAN. Cycle `NUM_VOICES`+1: COMMIT.
- `busy` is registered and high in cycles 1..`NUM_VOICES`+1.
- The voice register update and the `voice_start` pulse are visible in cycle `NUM_VOICES`+2.
- A new event is accepted in cycle `NUM_VOICES`+2 at the earliest, so throughput is one event per `NUM_VOICES`+2 cycles.
- `note_ready` in the same cycle that `busy` falls is accepted.
- All outputs are registered.
- Reset values (take effect immediately and asynchronously):
  - state IDLE, `busy`=0;
  - `voice_active`, `voice_note`, `voice_velocity`, `voice_start`, `drop_count` all 0;
  - age rank of voice i = i.
- Reset asserted mid-scan abandons the event with no voice change and no drop count.
- Scan inputs are the voice registers themselves. They cannot change during SCAN, so there are no hazards.

## Configuration
- Macro `VOICE_ALLOCATOR_STEAL_EN`.
- Defined: an ON event with all voices active steals the oldest voice (max rank), overwrites it and pulses its `voice_start`.
- Undefined: that event is dropped and `drop_count` increments. No rank logic beyond the free search is required, but ranks must still reset and update identically.

## Test plan
- Reset, then ON note 60 vel 100 -> in cycle 6 (`NUM_VOICES`=4): voice 0 active, note 60, vel 100; `voice_start`=4'b0001 for exactly one cycle; `busy` high in cycles 1-5.
- ON 60, 62, 64, 65, then OFF 62 -> `voice_active`=4'b1101; a following ON 67 lands in voice 1.
- ON 60 vel 100, then ON 60 vel 30 -> still only voice 0 active, velocity 30, second start pulse on voice 0.
- Voices full with 60, 62, 64, 65 in that order, then ON 67 -> with STEAL_EN, voice 0 gets note 67 and pulses start; without it, no change and `drop_count`=1.
- ON 60 vel 0 after ON 60 -> voice 0 released; OFF 70 with no match -> no change and `drop_count` unchanged.
- `note_ready` pulsed in cycle 2 of a scan -> ignored and `drop_count`=1; `reset_l` low in cycle 3 of a scan -> all outputs 0 immediately and no voice written.
